rob_multiport: RTL

Parametrised reorder buffer for the out-of-order core, sitting between rename/dispatch (allocation), the execution writeback buses (completion) and the retire stage (commit). It generalises allocation width, commit width and the number of writeback ports. It adds commit backpressure, partial squash of younger-than-branch entries, and the stale physical tag needed for free-list release. Pointers carry a wrap bit, so full and empty are unambiguous without a separate occupancy integer.

---
 rtl/rob_multiport_pkg.sv | 18 +
 rtl/rob_multiport_if.sv | 46 ++++
 rtl/rob_multiport_commit_sel.sv | 21 ++
 rtl/rob_multiport.sv | 102 ++++++++++
 4 files changed

// File: rtl/rob_multiport_pkg.sv
// rob_multiport_pkg: shared payload types for the reorder buffer
package rob_multiport_pkg;
  localparam int PREG_BITS = 6;
  typedef logic [PREG_BITS-1:0] preg_tag_t;
  typedef logic [4:0] arch_reg_t;
  typedef struct packed {
    logic valid;
    logic done;
    logic exception;
    arch_reg_t arch_rd;
    preg_tag_t phys_rd;
    preg_tag_t old_phys_rd;
    logic [31:0] pc;
    logic is_store;
    logic is_load;
    logic is_branch;
  } rob_entry_t;
endpackage

// File: rtl/rob_multiport_if.sv
// rob_multiport_if: allocation, writeback, commit and recovery signals of the reorder buffer
interface rob_multiport_if #(parameter int ALLOC_W = 2, COMMIT_W = 2, WB_PORTS = 3, IDX_BITS = 5);
  import rob_multiport_pkg::*;
  logic [ALLOC_W-1:0] alloc_valid;
  arch_reg_t [ALLOC_W-1:0] alloc_arch_rd;
  preg_tag_t [ALLOC_W-1:0] alloc_phys_rd;
  preg_tag_t [ALLOC_W-1:0] alloc_old_phys_rd;
  logic [ALLOC_W-1:0] alloc_is_store;
  logic [ALLOC_W-1:0] alloc_is_load;
  logic [ALLOC_W-1:0] alloc_is_branch;
  logic [ALLOC_W-1:0][31:0] alloc_pc;
  logic alloc_ready;
  logic [ALLOC_W-1:0][IDX_BITS-1:0] alloc_idx;
  logic [WB_PORTS-1:0] wb_valid;
  logic [WB_PORTS-1:0][IDX_BITS-1:0] wb_idx;
  logic [WB_PORTS-1:0] wb_exception;
  logic [COMMIT_W-1:0] commit_valid;
  arch_reg_t [COMMIT_W-1:0] commit_arch_rd;
  preg_tag_t [COMMIT_W-1:0] commit_phys_rd;
  preg_tag_t [COMMIT_W-1:0] commit_old_phys_rd;
  logic [COMMIT_W-1:0][31:0] commit_pc;
  logic [COMMIT_W-1:0] commit_is_store;
  logic [COMMIT_W-1:0] commit_is_load;
  logic [COMMIT_W-1:0] commit_is_branch;
  logic [COMMIT_W-1:0] commit_exception;
  logic [COMMIT_W-1:0][IDX_BITS-1:0] commit_idx;
  logic commit_ready;
  logic squash_en;
  logic [IDX_BITS-1:0] squash_idx;
  logic flush_en;
  logic [IDX_BITS:0] count;
  logic full;
  logic empty;
  modport master (
    output alloc_valid, alloc_arch_rd, alloc_phys_rd, alloc_old_phys_rd, alloc_is_store, alloc_is_load,
           alloc_is_branch, alloc_pc, wb_valid, wb_idx, wb_exception, commit_ready, squash_en, squash_idx, flush_en,
    input  alloc_ready, alloc_idx, commit_valid, commit_arch_rd, commit_phys_rd, commit_old_phys_rd, commit_pc,
           commit_is_store, commit_is_load, commit_is_branch, commit_exception, commit_idx, count, full, empty
  );
  modport slave (
    input  alloc_valid, alloc_arch_rd, alloc_phys_rd, alloc_old_phys_rd, alloc_is_store, alloc_is_load,
           alloc_is_branch, alloc_pc, wb_valid, wb_idx, wb_exception, commit_ready, squash_en, squash_idx, flush_en,
    output alloc_ready, alloc_idx, commit_valid, commit_arch_rd, commit_phys_rd, commit_old_phys_rd, commit_pc,
           commit_is_store, commit_is_load, commit_is_branch, commit_exception, commit_idx, count, full, empty
  );
endinterface

// File: rtl/rob_multiport_commit_sel.sv
// rob_multiport_commit_sel: prefix scan choosing which head entries retire this cycle
module rob_multiport_commit_sel #(parameter int COMMIT_W = 2, IDX_BITS = 5) (
  input  logic [COMMIT_W-1:0] ok,
  input  logic [COMMIT_W-1:0] exc,
  input  logic [IDX_BITS:0]   lim,
  output logic [COMMIT_W-1:0] mask,
  output logic [IDX_BITS:0]   n
);
  logic go;
  always_comb begin
    mask = '0;
    n = '0;
    go = 1'b1;
    for (int j = 0; j < COMMIT_W; j++) begin
      go = go && ok[j] && (j < int'(lim));
      mask[j] = go;
      n = n + (IDX_BITS+1)'(go);
      go = go && !exc[j];
    end
  end
endmodule

// File: rtl/rob_multiport.sv
// rob_multiport: reorder buffer with multi-slot allocate/commit, multi-port writeback, squash and flush
module rob_multiport
  import rob_multiport_pkg::*;
#(parameter int ROB_SIZE = 32, ALLOC_W = 2, COMMIT_W = 2, WB_PORTS = 3, IDX_BITS = $clog2(ROB_SIZE)) (
  input logic clk,
  input logic reset,
  rob_multiport_if.slave rob
);
  typedef logic [IDX_BITS-1:0] rob_idx_t;
  typedef logic [IDX_BITS:0] rob_ptr_t;
  localparam rob_ptr_t SIZE = rob_ptr_t'(ROB_SIZE);
  rob_ptr_t head, tail, cnt, sq_tail, lim, n_commit;
  rob_idx_t sq_off;
  rob_idx_t c_idx [COMMIT_W];
  rob_entry_t ent [ROB_SIZE];
  logic [ROB_SIZE-1:0] wb_hit, wb_exc, kill;
  logic [COMMIT_W-1:0] c_ok, c_exc, c_mask;
  logic do_alloc, sq_in;
  assign cnt = tail - head;
  assign rob.count = cnt;
  assign rob.full = cnt == SIZE;
  assign rob.empty = cnt == '0;
  // squash target as an offset into the live window, so its wrap bit follows from head
  assign sq_off = rob.squash_idx - head[IDX_BITS-1:0];
  assign sq_in = rob_ptr_t'(sq_off) < cnt;
  assign sq_tail = head + rob_ptr_t'(sq_off) + rob_ptr_t'(1);
  assign rob.alloc_ready = (SIZE - cnt) >= rob_ptr_t'($countones(rob.alloc_valid)) && !rob.flush_en &&
                           !rob.squash_en && ALLOC_W <= ROB_SIZE;
  assign do_alloc = rob.alloc_ready && |rob.alloc_valid;
  assign lim = rob.flush_en ? '0 : rob.squash_en ? rob_ptr_t'(sq_off) + rob_ptr_t'(1) : cnt;
  for (genvar k = 0; k < ALLOC_W; k++) begin : g_alloc
    assign rob.alloc_idx[k] = tail[IDX_BITS-1:0] + rob_idx_t'(k);
  end
  for (genvar i = 0; i < ROB_SIZE; i++) begin : g_kill
    rob_idx_t off;
    assign off = rob_idx_t'(i) - head[IDX_BITS-1:0];
    assign kill[i] = rob.squash_en && off > sq_off && rob_ptr_t'(off) < cnt;
  end
  for (genvar j = 0; j < COMMIT_W; j++) begin : g_commit
    logic v;
    assign c_idx[j] = head[IDX_BITS-1:0] + rob_idx_t'(j);
    assign c_ok[j] = ent[c_idx[j]].valid && ent[c_idx[j]].done;
    assign c_exc[j] = ent[c_idx[j]].exception;
    assign v = c_mask[j];
    assign rob.commit_valid[j] = v;
    assign rob.commit_idx[j] = v ? c_idx[j] : '0;
    assign rob.commit_arch_rd[j] = v ? ent[c_idx[j]].arch_rd : '0;
    assign rob.commit_phys_rd[j] = v ? ent[c_idx[j]].phys_rd : '0;
    assign rob.commit_old_phys_rd[j] = v ? ent[c_idx[j]].old_phys_rd : '0;
    assign rob.commit_pc[j] = v ? ent[c_idx[j]].pc : '0;
    assign rob.commit_is_store[j] = v && ent[c_idx[j]].is_store;
    assign rob.commit_is_load[j] = v && ent[c_idx[j]].is_load;
    assign rob.commit_is_branch[j] = v && ent[c_idx[j]].is_branch;
    assign rob.commit_exception[j] = v && ent[c_idx[j]].exception;
  end
  rob_multiport_commit_sel #(.COMMIT_W(COMMIT_W), .IDX_BITS(IDX_BITS)) u_sel (
    .ok(c_ok), .exc(c_exc), .lim(lim), .mask(c_mask), .n(n_commit)
  );
  always_comb begin
    wb_hit = '0;
    wb_exc = '0;
    for (int p = 0; p < WB_PORTS; p++)
      if (rob.wb_valid[p]) begin
        wb_hit[rob.wb_idx[p]] = 1'b1;
        wb_exc[rob.wb_idx[p]] = wb_exc[rob.wb_idx[p]] | rob.wb_exception[p];
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
    end else if (rob.flush_en) begin
      tail <= head;
      for (int i = 0; i < ROB_SIZE; i++) ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (wb_hit[i] && ent[i].valid) begin
          ent[i].done <= 1'b1;
          ent[i].exception <= ent[i].exception | wb_exc[i];
        end
        if (kill[i]) ent[i].valid <= 1'b0;
      end
      if (rob.commit_ready) begin
        head <= head + n_commit;
        for (int j = 0; j < COMMIT_W; j++) if (c_mask[j]) ent[c_idx[j]].valid <= 1'b0;
      end
      if (do_alloc) begin
        tail <= tail + rob_ptr_t'($countones(rob.alloc_valid));
        for (int k = 0; k < ALLOC_W; k++)
          if (rob.alloc_valid[k])
            ent[rob.alloc_idx[k]] <= '{valid: 1'b1, done: 1'b0, exception: 1'b0,
                                       arch_rd: rob.alloc_arch_rd[k], phys_rd: rob.alloc_phys_rd[k],
                                       old_phys_rd: rob.alloc_old_phys_rd[k], pc: rob.alloc_pc[k],
                                       is_store: rob.alloc_is_store[k], is_load: rob.alloc_is_load[k],
                                       is_branch: rob.alloc_is_branch[k]};
      end
      if (rob.squash_en) tail <= sq_tail;
    end
  always @(posedge clk)
    if (!reset && rob.squash_en && !rob.flush_en) assert (sq_in);
endmodule
